// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared condition codes, NZCV flag type and ALU control constants
package cpu_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_HS = 4'b0010;
    localparam logic [3:0] COND_LO = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [2:0] ALU_PASS_B   = 3'b000;
    localparam logic [2:0] ALU_ADD      = 3'b010;
    localparam logic [2:0] ALU_SUBTRACT = 3'b011;
    localparam logic [2:0] ALU_AND      = 3'b100;
    localparam logic [2:0] ALU_OR       = 3'b101;
    localparam logic [2:0] ALU_XOR      = 3'b110;

    // Bit order matches the architectural {N,Z,C,V} view.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational condition-code evaluation against NZCV flags
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  nzcv_t      flags,
    output logic       taken
);

    // Decode the condition code against the supplied flags; 1110/1111 always taken.
    always_comb begin
        taken = 1'b1;
        case (cond)
            COND_EQ: taken = flags.z;
            COND_NE: taken = !flags.z;
            COND_HS: taken = flags.c;
            COND_LO: taken = !flags.c;
            COND_MI: taken = flags.n;
            COND_PL: taken = !flags.n;
            COND_VS: taken = flags.v;
            COND_VC: taken = !flags.v;
            COND_HI: taken = flags.c && !flags.z;
            COND_LS: taken = !flags.c || flags.z;
            COND_GE: taken = (flags.n == flags.v);
            COND_LT: taken = (flags.n != flags.v);
            COND_GT: taken = !flags.z && (flags.n == flags.v);
            COND_LE: taken = flags.z || (flags.n != flags.v);
            default: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/exmem_stage.sv
// rtl/exmem_stage.sv - EX/MEM pipeline register with NZCV flags and branch resolution (option: BCOND_EVAL_EN)
module exmem_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ex_valid,
    input  logic [63:0] ex_result,
    input  logic        ex_negative,
    input  logic        ex_zero,
    input  logic        ex_overflow,
    input  logic        ex_carry_out,
    input  logic        ex_set_flags,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [63:0] ex_store_data,
    input  logic        ex_is_bcond,
    input  logic        ex_is_cbz,
    input  logic        ex_is_cbnz,
    input  logic [3:0]  ex_cond,
    input  logic        stall,
    input  logic        flush,
    output logic        mem_valid,
    output logic        mem_reg_write,
    output logic        mem_mem_read,
    output logic        mem_mem_write,
    output logic [63:0] mem_result,
    output logic [63:0] mem_store_data,
    output logic [4:0]  mem_rd,
    output logic        mem_br_taken,
    output logic [3:0]  flags_q
);

    nzcv_t flags_r;
    logic  br_taken_d;

    assign flags_q = flags_r;

`ifdef BCOND_EVAL_EN
    logic bcond_taken;

    // B.cond looks at the committed flags; CBZ/CBNZ look at the live ALU zero flag.
    cond_eval u_cond_eval (
        .cond  (ex_cond),
        .flags (flags_r),
        .taken (bcond_taken)
    );

    assign br_taken_d = ex_valid && ((ex_is_bcond && bcond_taken) ||
                                     (ex_is_cbz   && ex_zero)     ||
                                     (ex_is_cbnz  && !ex_zero));
`else
    logic unused_branch_inputs;

    assign unused_branch_inputs = ^{ex_is_bcond, ex_is_cbz, ex_is_cbnz, ex_cond};
    assign br_taken_d = 1'b0;
`endif

    // Pipeline register: flush clears control, stall holds everything, invalid EX bubbles control.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_valid      <= 1'b0;
            mem_reg_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_br_taken   <= 1'b0;
            mem_result     <= '0;
            mem_store_data <= '0;
            mem_rd         <= '0;
        end else if (flush) begin
            mem_valid      <= 1'b0;
            mem_reg_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_br_taken   <= 1'b0;
        end else if (!stall) begin
            mem_valid      <= ex_valid;
            mem_reg_write  <= ex_valid && ex_reg_write;
            mem_mem_read   <= ex_valid && ex_mem_read;
            mem_mem_write  <= ex_valid && ex_mem_write;
            mem_br_taken   <= br_taken_d;
            mem_result     <= ex_result;
            mem_store_data <= ex_store_data;
            mem_rd         <= ex_rd;
        end
    end

    // Architectural flags update only for a valid, advancing flag-setting instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_r <= '0;
        end else if (ex_valid && ex_set_flags && !stall && !flush) begin
            flags_r <= '{n: ex_negative, z: ex_zero, c: ex_carry_out, v: ex_overflow};
        end
    end

endmodule
